// File: rtl/fetch_predict.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, and predicts
// conditional branches with a bimodal table of 2-bit saturating counters.
module fetch_predict #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int unsigned BHT_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  input  logic        Update_valid_IN,
  input  logic [31:0] Update_PC_IN,
  input  logic        Update_taken_IN,
  output logic [31:0] Instr_address_2IM,
  input  logic [31:0] Instr_fIM,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] Instr1_PC_Plus4_OUT,
  output logic        Branch_prediction_OUT
);

  localparam int unsigned BHT_SIZE = 1 << BHT_BITS;

  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instr_pc4;
  logic        r_pred;
  logic [1:0]  r_bht [BHT_SIZE];

  logic [5:0]          w_opcode;
  logic                w_is_cond;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_target;
  logic [BHT_BITS-1:0] w_idx;
  logic [BHT_BITS-1:0] w_upd_idx;
  logic [1:0]          w_upd_ctr;
  logic                w_pred;
  logic                w_redirect;
  logic [31:0]         w_next_pc;

  assign Instr_address_2IM     = r_pc;
  assign Instr1_OUT            = r_instr;
  assign Instr1_PC_OUT         = r_instr_pc;
  assign Instr1_PC_Plus4_OUT   = r_instr_pc4;
  assign Branch_prediction_OUT = r_pred;

  assign w_opcode   = Instr_fIM[31:26];
  assign w_is_cond  = (w_opcode == 6'd1) || (w_opcode == 6'd4) || (w_opcode == 6'd5) ||
                      (w_opcode == 6'd6) || (w_opcode == 6'd7);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = w_pc_plus4 + {{14{Instr_fIM[15]}}, Instr_fIM[15:0], 2'b00};
  assign w_idx      = r_pc[BHT_BITS+1:2];
  assign w_pred     = w_is_cond && r_bht[w_idx][1];
  assign w_next_pc  = w_pred ? w_target : w_pc_plus4;

  // A pending redirect only fires once the freeze lifts; a live request always counts.
  assign w_redirect = Request_Alt_PC_IN || (r_pend_valid && !WANT_FREEZE_IN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
      r_instr_pc4  <= '0;
      r_pred       <= 1'b0;
    end else if (w_redirect) begin
      if (!WANT_FREEZE_IN) begin
        r_pc         <= Request_Alt_PC_IN ? Alt_PC_IN : r_pend_pc;
        r_pend_valid <= 1'b0;
        r_instr      <= '0;
        r_instr_pc   <= '0;
        r_instr_pc4  <= '0;
        r_pred       <= 1'b0;
      end else begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= Alt_PC_IN;
      end
    end else if (!WANT_FREEZE_IN) begin
      r_pc <= w_next_pc;
      if (FLUSH) begin
        r_instr     <= '0;
        r_instr_pc  <= '0;
        r_instr_pc4 <= '0;
        r_pred      <= 1'b0;
      end else begin
        r_instr     <= Instr_fIM;
        r_instr_pc  <= r_pc;
        r_instr_pc4 <= w_pc_plus4;
        r_pred      <= w_pred;
      end
    end
  end

  assign w_upd_idx = Update_PC_IN[BHT_BITS+1:2];
  assign w_upd_ctr = r_bht[w_upd_idx];

  // Training ignores freeze and flush; lookup above sees the pre-update value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bht <= '{default: 2'b01};
    end else if (Update_valid_IN) begin
      if (Update_taken_IN && (w_upd_ctr != 2'b11))
        r_bht[w_upd_idx] <= w_upd_ctr + 2'd1;
      else if (!Update_taken_IN && (w_upd_ctr != 2'b00))
        r_bht[w_upd_idx] <= w_upd_ctr - 2'd1;
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed self-checking bench for fetch_predict: reset, sequential fetch,
// prediction, redirect, flush, freeze with pending redirect, training, reset mid-redirect.
module tb_fetch_predict;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, Request_Alt_PC_IN, WANT_FREEZE_IN;
  logic        Update_valid_IN, Update_taken_IN;
  logic [31:0] Alt_PC_IN, Update_PC_IN, Instr_fIM, Instr_address_2IM;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;

  logic [31:0] br_addr = 32'hFFFF_FFFF;
  logic [31:0] br_word = 32'h0;
  int n_checks = 0;
  int n_errors = 0;
  logic [96:0] obs, exp_v;

  fetch_predict dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .Alt_PC_IN(Alt_PC_IN), .Request_Alt_PC_IN(Request_Alt_PC_IN),
    .WANT_FREEZE_IN(WANT_FREEZE_IN),
    .Update_valid_IN(Update_valid_IN), .Update_PC_IN(Update_PC_IN),
    .Update_taken_IN(Update_taken_IN),
    .Instr_address_2IM(Instr_address_2IM), .Instr_fIM(Instr_fIM),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .Instr1_PC_Plus4_OUT(Instr1_PC_Plus4_OUT),
    .Branch_prediction_OUT(Branch_prediction_OUT)
  );

  always #5 CLK = ~CLK;

  // Memory holds NOPs except for one programmable branch word.
  always_comb Instr_fIM = (Instr_address_2IM == br_addr) ? br_word : 32'h0;

  assign obs = {Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT, Branch_prediction_OUT};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    n_checks++;
    if (obs !== 97'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    n_checks++;
    if (Instr_address_2IM !== 32'hBFC00000) begin
      n_errors++; $display("FAIL reset_pc: got %h expected BFC00000", Instr_address_2IM);
    end
    RESET = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      exp_v = {32'h0, 32'hBFC00000 + 32'(4 * k), 32'hBFC00004 + 32'(4 * k), 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++; $display("FAIL seq_fetch_%0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_branch_predict();
    // Train index 4 to weakly-taken while frozen; outputs must hold.
    br_addr = 32'hBFC00010;
    br_word = 32'h10000003;
    WANT_FREEZE_IN = 1'b1;
    Update_valid_IN = 1'b1; Update_PC_IN = 32'hBFC00010; Update_taken_IN = 1'b1;
    tick();
    Update_valid_IN = 1'b0;
    WANT_FREEZE_IN = 1'b0;
    exp_v = {32'h0, 32'hBFC0000C, 32'hBFC00010, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL freeze_hold_train: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {32'h10000003, 32'hBFC00010, 32'hBFC00014, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL beq_predicted: got %h expected %h", obs, exp_v);
    end
    n_checks++;
    if (Instr_address_2IM !== 32'hBFC00020) begin
      n_errors++; $display("FAIL beq_target: got %h expected BFC00020", Instr_address_2IM);
    end
    tick();
    exp_v = {32'h0, 32'hBFC00020, 32'hBFC00024, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL after_taken: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_redirect_flush();
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00400000;
    tick();
    Request_Alt_PC_IN = 1'b0;
    n_checks++;
    if (obs !== 97'd0 || Instr_address_2IM !== 32'h00400000) begin
      n_errors++; $display("FAIL redirect_bubble: got %h pc %h expected 0 pc 00400000", obs, Instr_address_2IM);
    end
    tick();
    exp_v = {32'h0, 32'h00400000, 32'h00400004, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL redirect_target: got %h expected %h", obs, exp_v);
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    n_checks++;
    if (obs !== 97'd0 || Instr_address_2IM !== 32'h00400008) begin
      n_errors++; $display("FAIL flush: got %h pc %h expected 0 pc 00400008", obs, Instr_address_2IM);
    end
    tick();
    exp_v = {32'h0, 32'h00400008, 32'h0040000C, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL after_flush: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_freeze_pending();
    exp_v = {32'h0, 32'h00400008, 32'h0040000C, 1'b0};
    WANT_FREEZE_IN = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      Request_Alt_PC_IN = (k == 1);
      Alt_PC_IN = 32'h00400100;
      tick();
      n_checks++;
      if (obs !== exp_v || Instr_address_2IM !== 32'h0040000C) begin
        n_errors++;
        $display("FAIL freeze_hold_%0d: got %h pc %h expected %h pc 0040000C", k, obs, Instr_address_2IM, exp_v);
      end
    end
    Request_Alt_PC_IN = 1'b0;
    WANT_FREEZE_IN = 1'b0;
    tick();
    n_checks++;
    if (obs !== 97'd0 || Instr_address_2IM !== 32'h00400100) begin
      n_errors++; $display("FAIL pending_bubble: got %h pc %h expected 0 pc 00400100", obs, Instr_address_2IM);
    end
    tick();
    exp_v = {32'h0, 32'h00400100, 32'h00400104, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL pending_target: got %h expected %h", obs, exp_v);
    end
  endtask

  // Redirect to the idx-5 branch (optionally training in the redirect cycle and/or
  // the lookup cycle) and check the prediction it is fetched with.
  task automatic probe5(input logic upd_a, input logic tk_a,
                        input logic upd_b, input logic tk_b,
                        input logic exp_pred, input int step);
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00400114;
    Update_valid_IN = upd_a; Update_PC_IN = 32'h00000014; Update_taken_IN = tk_a;
    tick();
    Request_Alt_PC_IN = 1'b0;
    Update_valid_IN = upd_b; Update_taken_IN = tk_b;
    tick();
    Update_valid_IN = 1'b0;
    exp_v = {32'h14000003, 32'h00400114, 32'h00400118, exp_pred};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL train_step_%0d: got %h expected %h", step, obs, exp_v);
    end
  endtask

  task automatic test_training();
    br_addr = 32'h00400114;
    br_word = 32'h14000003;
    probe5(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0); // 01
    probe5(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1); // 10
    probe5(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2); // 11
    probe5(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3); // stays 11
    probe5(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4); // 10
    probe5(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5); // 01
    probe5(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6); // lookup sees 01, then becomes 10
    probe5(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7); // 10
  endtask

  task automatic test_reset_mid_redirect();
    WANT_FREEZE_IN = 1'b1;
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00400200;
    tick();
    RESET = 1'b1;
    tick();
    n_checks++;
    if (obs !== 97'd0 || Instr_address_2IM !== 32'hBFC00000) begin
      n_errors++; $display("FAIL reset_mid_redirect: got %h pc %h expected 0 pc BFC00000", obs, Instr_address_2IM);
    end
    RESET = 1'b0; WANT_FREEZE_IN = 1'b0; Request_Alt_PC_IN = 1'b0;
    br_addr = 32'hBFC00010;
    br_word = 32'h10000003;
    tick();
    exp_v = {32'h0, 32'hBFC00000, 32'hBFC00004, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++; $display("FAIL pending_dropped: got %h expected %h", obs, exp_v);
    end
    for (int unsigned k = 0; k < 4; k++) tick();
    exp_v = {32'h10000003, 32'hBFC00010, 32'hBFC00014, 1'b0};
    n_checks++;
    if (obs !== exp_v || Instr_address_2IM !== 32'hBFC00014) begin
      n_errors++; $display("FAIL counters_reset: got %h pc %h expected %h pc BFC00014", obs, Instr_address_2IM, exp_v);
    end
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; Request_Alt_PC_IN = 1'b0; WANT_FREEZE_IN = 1'b0;
    Alt_PC_IN = '0; Update_valid_IN = 1'b0; Update_PC_IN = '0; Update_taken_IN = 1'b0;
    test_reset();
    test_branch_predict();
    test_redirect_flush();
    test_freeze_pending();
    test_training();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
